// File: rtl/saturn_debug_uart_tx.sv
// rtl/saturn_debug_uart_tx.sv - FIFO-buffered 8N1 UART transmitter for debug characters
// Optional SATURN_DEBUG_UART_CRLF_EN: a popped 0x0A is sent as 0x0D then 0x0A.
module saturn_debug_uart_tx #(
    parameter int CLK_DIV = 104,
    parameter int FIFO_AW = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_char_valid,
    input  logic [7:0]         i_char,
    output logic               o_char_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_level
);
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic [15:0]          r_baud;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_done;
    logic                 w_relaunch;
    logic [7:0]           w_head;
    logic [7:0]           w_next_byte;

    assign w_full     = (r_count == FULL_CNT);
    assign w_push     = i_char_valid && !w_full;
    assign w_bit_done = (r_baud == 16'd0);
    assign w_head     = r_mem[r_rd_ptr];

`ifdef SATURN_DEBUG_UART_CRLF_EN
    logic r_lf_pending;

    // The 0x0A of a CR/LF pair is replayed from STOP without touching the FIFO.
    assign w_relaunch  = (r_state == S_STOP) && w_bit_done && r_lf_pending;
    assign w_pop       = (r_count != '0) && !r_lf_pending &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign w_next_byte = r_lf_pending ? 8'h0A : ((w_head == 8'h0A) ? 8'h0D : w_head);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lf_pending <= 1'b0;
        end else if (w_pop) begin
            r_lf_pending <= (w_head == 8'h0A);
        end else if (w_relaunch) begin
            r_lf_pending <= 1'b0;
        end
    end
`else
    assign w_relaunch  = 1'b0;
    assign w_pop       = (r_count != '0) &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign w_next_byte = w_head;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_char;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_char_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= w_next_byte;
                        r_baud  <= BAUD_LAST;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= 3'd0;
                        r_baud    <= BAUD_LAST;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_baud <= BAUD_LAST;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        // Chain straight into the next start bit so frames have no idle gap.
                        if (w_pop || w_relaunch) begin
                            r_state <= S_START;
                            r_shift <= w_next_byte;
                            r_baud  <= BAUD_LAST;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_char_ready = !w_full;
    assign o_tx         = r_tx;
    assign o_busy       = (r_count != '0) || (r_state != S_IDLE);
    assign o_overflow   = r_overflow;
    assign o_level      = r_count;

endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
// tb/tb_saturn_debug_uart_tx.sv - self-checking bench for saturn_debug_uart_tx (CLK_DIV=4, FIFO_AW=2)
module tb_saturn_debug_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_char_valid = 1'b0;
    logic [7:0]       i_char = 8'd0;
    logic             o_char_ready;
    logic             o_tx;
    logic             o_busy;
    logic             o_overflow;
    logic [FIFO_AW:0] o_level;

    saturn_debug_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_char_valid(i_char_valid),
        .i_char(i_char),
        .o_char_ready(o_char_ready),
        .o_tx(o_tx),
        .o_busy(o_busy),
        .o_overflow(o_overflow),
        .o_level(o_level)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_byte;

    typedef struct {
        logic [7:0] ch;
        logic [9:0] line;
    } vec_t;
    vec_t tbl[6];

    // Line receiver: decodes frames by sampling bit centres on the falling clock.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_tx == 1'b0) begin
                start_q.push_back(cyc);
                repeat (2) @(negedge i_clk);
                if (o_tx !== 1'b0) frame_err++;
                for (int k = 0; k < 8; k++) begin
                    repeat (4) @(negedge i_clk);
                    mon_byte[k] = o_tx;
                end
                repeat (4) @(negedge i_clk);
                if (o_tx !== 1'b1) frame_err++;
                rx_q.push_back(mon_byte);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] b);
`ifdef SATURN_DEBUG_UART_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endfunction

    task automatic clear_q();
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int limit, input string name, output int fall_cyc);
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) begin
            checks++;
            failures++;
            $display("FAIL %s timeout busy=%0d after %0d cycles", name, o_busy, limit);
        end
        fall_cyc = cyc;
    endtask

    task automatic compare_rx(input string name);
        chk({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_char_valid = 1'b1;
        i_char = b;
        @(posedge i_clk);
        #1;
        i_char_valid = 1'b0;
    endtask

    // Single frame from idle: checks latency, every bit centre and the busy drop edge.
    task automatic check_frame(input logic [7:0] ch, input logic [9:0] line, input string name);
        rx_q.delete();
        write_byte(ch);
        chk({name, "_level_after_write"}, 32'(o_level), 32'd1);
        chk({name, "_tx_before_start"}, 32'(o_tx), 32'd1);
        @(posedge i_clk);
        #1;
        chk({name, "_start_fall"}, 32'(o_tx), 32'd0);
        for (int k = 0; k < 10; k++) begin
            repeat (2) @(posedge i_clk);
            #1;
            chk($sformatf("%s_bit%0d", name, k), 32'(o_tx), 32'(line[k]));
            if (k < 9) begin
                repeat (2) @(posedge i_clk);
            end else begin
                @(posedge i_clk);
                #1;
                chk({name, "_busy_clk39"}, 32'(o_busy), 32'd1);
                @(posedge i_clk);
                #1;
            end
        end
        chk({name, "_busy_clk40"}, 32'(o_busy), 32'd0);
        chk({name, "_level_end"}, 32'(o_level), 32'd0);
        chk({name, "_rx_count"}, 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk({name, "_rx_byte"}, 32'(rx_q[0]), 32'(ch));
    endtask

    initial begin
        int fall;
        int lows;
        int n;
        logic [7:0] b;
        logic [7:0] ovf_bytes[6];

        tbl[0] = '{ch: 8'h55, line: 10'h2AA};
        tbl[1] = '{ch: 8'h00, line: 10'h200};
        tbl[2] = '{ch: 8'hFF, line: 10'h3FE};
        tbl[3] = '{ch: 8'hA5, line: 10'h34A};
        tbl[4] = '{ch: 8'h41, line: 10'h282};
        tbl[5] = '{ch: 8'h96, line: 10'h32C};

        repeat (3) @(negedge i_clk);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_ready", 32'(o_char_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        for (int i = 0; i < 6; i++)
            check_frame(tbl[i].ch, tbl[i].line, $sformatf("vec%0d", i));

        // Burst of three on consecutive cycles: contiguous frames, 120 clocks total.
        clear_q();
        foreach (tbl[i]) if (i < 0) n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_char_valid = 1'b1;
            i_char = 8'h41 + 8'(i);
            model_push(8'h41 + 8'(i));
        end
        @(negedge i_clk);
        i_char_valid = 1'b0;
        wait_idle(400, "burst", fall);
        compare_rx("burst");
        chk("burst_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            chk("burst_gap01", 32'(start_q[1] - start_q[0]), 32'd40);
            chk("burst_gap12", 32'(start_q[2] - start_q[1]), 32'd40);
            chk("burst_total", 32'(fall - start_q[0]), 32'd120);
        end

        // Six writes into a four-deep FIFO: the first pops, the sixth is dropped.
        clear_q();
        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            i_char_valid = 1'b1;
            i_char = ovf_bytes[i];
            if (i < 5) model_push(ovf_bytes[i]);
            @(posedge i_clk);
            #1;
            if (i == 3) chk("ovf_ready_lvl3", 32'(o_char_ready), 32'd1);
            if (i == 4) begin
                chk("ovf_level_full", 32'(o_level), 32'd4);
                chk("ovf_ready_full", 32'(o_char_ready), 32'd0);
                chk("ovf_flag_before", 32'(o_overflow), 32'd0);
            end
            if (i == 5) begin
                chk("ovf_flag_set", 32'(o_overflow), 32'd1);
                chk("ovf_level_hold", 32'(o_level), 32'd4);
            end
        end
        @(negedge i_clk);
        i_char_valid = 1'b0;
        wait_idle(600, "ovf", fall);
        compare_rx("ovf");
        chk("ovf_flag_sticky", 32'(o_overflow), 32'd1);

        // Reset at clock 17 of a frame aborts it and discards the FIFO.
        write_byte(8'h3C);
        write_byte(8'hC3);
        repeat (16) @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(o_tx), 32'd1);
        chk("rst_mid_level", 32'(o_level), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_overflow", 32'(o_overflow), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (o_tx == 1'b0) lows++;
        end
        chk("rst_no_frames", 32'(lows), 32'd0);
        clear_q();
        check_frame(tbl[5].ch, tbl[5].line, "post_rst");

        // Line feed: CR/LF pair from one pop when the option is built in.
        clear_q();
        write_byte(8'h0A);
        model_push(8'h0A);
        wait_idle(400, "lf", fall);
        compare_rx("lf");
        if (start_q.size() > 0)
            chk("lf_duration", 32'(fall - start_q[0]), 32'(40 * exp_q.size()));
        else
            chk("lf_started", 32'(start_q.size()), 32'd1);

        // Pointer wrap: twenty spaced writes, none dropped.
        clear_q();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h0A) b = 8'h0B;
            model_push(b);
            write_byte(b);
            repeat (39) @(posedge i_clk);
        end
        wait_idle(400, "wrap", fall);
        compare_rx("wrap");
        chk("wrap_overflow", 32'(o_overflow), 32'd0);

        // Random bursts of up to four bytes, including line feeds.
        for (int r = 0; r < 6; r++) begin
            clear_q();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) b = 8'h0A;
                model_push(b);
                @(negedge i_clk);
                i_char_valid = 1'b1;
                i_char = b;
            end
            @(negedge i_clk);
            i_char_valid = 1'b0;
            wait_idle(800, $sformatf("rand%0d", r), fall);
            compare_rx($sformatf("rand%0d", r));
            if (start_q.size() > 0)
                chk($sformatf("rand%0d_duration", r), 32'(fall - start_q[0]), 32'(40 * exp_q.size()));
        end
        chk("rand_overflow", 32'(o_overflow), 32'd0);
        chk("framing_errors", 32'(frame_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/saturn_debug_uart_tx.md
# saturn_debug_uart_tx

Downstream consumer of the bus controller's debug character output (`o_char_to_send`). It buffers characters in a small FIFO and serialises them as 8N1 UART frames on a single TX pin, so debug traces reach a host terminal without stalling the core. It sits beside `saturn_bus` at board top level. Its only link back into the core is a ready/overflow indication.

## Interface
Parameters:
- `CLK_DIV`, default 104: clocks per UART bit. Legal range is 2..65535; the counter is 16 bits.
- `FIFO_AW`, default 4: FIFO address width. Depth is 2^FIFO_AW entries.

Ports:
- `i_clk`, input, 1: single clock; every register is clocked on its rising edge.
- `i_reset`, input, 1: reset, asynchronous and active-high.
- `i_char_valid`, input, 1: strobe; `i_char` is offered this cycle.
- `i_char`, input, 8: character from the bus controller's `o_char_to_send`.
- `o_char_ready`, output, 1: high when the FIFO is not full.
- `o_tx`, output, 1: UART line. Idle is high.
- `o_busy`, output, 1: high when the FIFO is non-empty or a frame is in progress.
- `o_overflow`, output, 1: sticky flag; a character was dropped.
- `o_level`, output, FIFO_AW+1: current FIFO occupancy.

## Operation
- FIFO
  - Circular buffer with FIFO_AW-bit read and write pointers and a FIFO_AW+1-bit count.
  - Write on `i_char_valid && o_char_ready`.
  - If `i_char_valid` is high and the FIFO is full, the character is dropped and `o_overflow` is set. A pop in the same cycle does not rescue it, because `o_char_ready` comes from the registered count.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- TX state machine states: IDLE, START, DATA, STOP.
  - IDLE → START: when the FIFO is non-empty. Pop one byte into the shift register, load the baud counter with CLK_DIV-1, and drive `o_tx` = 0.
  - START → DATA: when the baud counter reaches 0. Drive bit 0. Bit index = 0.
  - DATA: send LSB first. Each bit is held for CLK_DIV cycles. After bit 7 expires, go to STOP and drive `o_tx` = 1.
  - STOP → START: after CLK_DIV cycles, if the FIFO is non-empty (no idle gap between frames). Otherwise STOP → IDLE.
- The baud counter is a 16-bit down-counter. It reloads to CLK_DIV-1 at every bit boundary.
- `o_tx` is driven directly from a register, so the line is glitch-free.
- Reset
  - Reset values: `o_tx` = 1, `o_char_ready` = 1, `o_busy` = 0, `o_overflow` = 0, `o_level` = 0, state = IDLE, pointers = 0.
  - `o_overflow` is cleared only by reset.
  - Reset asserted mid-frame aborts the frame: `o_tx` goes high immediately (asynchronously) and the FIFO contents are discarded.

## Timing
- A character accepted at clock edge N appears in `o_level` after edge N.
- With an empty FIFO and the FSM in IDLE, the start bit falling edge occurs at edge N+1.
- `o_char_ready` deasserts in the cycle after the write that filled the FIFO.
- `o_char_ready` reasserts in the cycle after the pop that frees a slot.
- Frame length is exactly 10×CLK_DIV clocks: start, 8 data bits, stop.
- Back-to-back frames have zero gap.
- `o_busy` falls at the edge where STOP expires with the FIFO empty.

## Configuration
- `SATURN_DEBUG_UART_CRLF_EN` defined:
  - A popped 0x0A is sent as two frames, 0x0D then 0x0A.
  - The FSM goes STOP → START for the 0x0A without popping.
  - `o_busy` stays high across both frames.
- Not defined: every byte is sent verbatim and there is no extra state.

## Test plan
- Reset, CLK_DIV=4: write 0x55 → `o_tx` falls 1 edge later; the line reads 0,1,0,1,0,1,0,1,0,1 over 40 clocks; `o_busy` drops at clock 40; `o_level` is back to 0.
- Burst of 3 bytes (0x41, 0x42, 0x43) on consecutive cycles → three contiguous frames totalling 120 clocks, no idle high between frames, correct LSB-first bits.
- FIFO_AW=2: write 6 bytes while the first frame is in progress:
  - `o_char_ready` = 0 once `o_level` reaches 4;
  - the 6th write is dropped and `o_overflow` = 1, staying 1 until reset;
  - exactly 5 frames are sent, because the first pop frees one slot.
- Assert `i_reset` at clock 17 of a frame → `o_tx` = 1 in the same cycle, `o_level` = 0, no further frames; after release, a new write transmits normally.
- With `SATURN_DEBUG_UART_CRLF_EN`: write 0x0A → frames 0x0D, 0x0A (80 clocks at CLK_DIV=4), and only one FIFO pop. Without the macro: a single 0x0A frame of 40 clocks.
- Pointer wrap: 20 writes spaced by 40 clocks with FIFO_AW=2 → all 20 bytes received in order, `o_overflow` stays 0.
